// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=4 (8-state) Viterbi decoder.
//   N_STATES / STATE_W / PRED_W : trellis size and predecessor-table width
//   tb_state_e                  : traceback controller FSM encoding
//   pred_tbl_t                  : one step's predecessor table, entry k = pred of state k
package viterbi_pkg;

  localparam int unsigned N_STATES = 8;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PRED_W   = N_STATES * STATE_W;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    TRACE  = 2'd1,
    EMIT   = 2'd2
  } tb_state_e;

  // Packed so that entry k occupies bits [3k+2:3k] of the 24-bit bus.
  typedef logic [N_STATES-1:0][STATE_W-1:0] pred_tbl_t;

endpackage

// File: rtl/viterbi_tb_ctrl_mux.sv
// 8:1 selector of 3-bit predecessor fields.
//   in0..in7 : candidate 3-bit values
//   sel      : index of the field to pass through
//   out      : selected field (combinational)
module mux8to1_3bit (
  input  logic [2:0] in0,
  input  logic [2:0] in1,
  input  logic [2:0] in2,
  input  logic [2:0] in3,
  input  logic [2:0] in4,
  input  logic [2:0] in5,
  input  logic [2:0] in6,
  input  logic [2:0] in7,
  input  logic [2:0] sel,
  output logic [2:0] out
);

  always_comb begin
    out = '0;
    case (sel)
      3'd0: out = in0;
      3'd1: out = in1;
      3'd2: out = in2;
      3'd3: out = in3;
      3'd4: out = in4;
      3'd5: out = in5;
      3'd6: out = in6;
      3'd7: out = in7;
    endcase
  end

endmodule

// File: rtl/viterbi_tb_ctrl.sv
// Sliding-window traceback controller for the 8-state Viterbi decoder.
// Stores predecessor tables in a circular survivor memory; once the window
// is full, every accepted step triggers a TB_DEPTH-1 hop traceback from the
// best state and emits the decoded bit of the oldest state in the window.
//   clk, rst            : clock, synchronous active-high reset
//   pred_in, best_in    : predecessor table and best state of one step
//   in_valid, in_ready  : step handshake (in_ready only in ACCEPT)
//   bit_out, out_valid  : decoded bit handshake (registered)
//   out_ready           : downstream accepts bit_out
// Optional (VITERBI_TB_DBG_EN): dbg_fsm (current state), dbg_bit_cnt (bits emitted).
module viterbi_tb_ctrl
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PRED_W-1:0] pred_in,
  input  logic [STATE_W-1:0] best_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bit_out,
  output logic              out_valid,
  input  logic              out_ready
`ifdef VITERBI_TB_DBG_EN
  ,
  output logic [1:0]        dbg_fsm,
  output logic [15:0]       dbg_bit_cnt
`endif
);

  localparam int unsigned FILL_W = ADDR_W + 1;
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(TB_DEPTH);
  localparam logic [ADDR_W-1:0] HOP_INIT = ADDR_W'(TB_DEPTH - 1);

  tb_state_e           state, state_nxt;
  logic [ADDR_W-1:0]   wp, wp_nxt;
  logic [ADDR_W-1:0]   rp, rp_nxt;
  logic [ADDR_W-1:0]   hop, hop_nxt;
  logic [FILL_W-1:0]   fill_cnt, fill_nxt, fill_inc;
  logic [STATE_W-1:0]  cur, cur_nxt;
  logic [STATE_W-1:0]  pred_sel;
  logic                bit_nxt, ov_nxt;
  logic                mem_we;
  pred_tbl_t           mem [TB_DEPTH];
  pred_tbl_t           rd_tbl;

  assign in_ready = (state == ACCEPT) & ~rst;
  assign rd_tbl   = mem[rp];
  // Saturating fill count: once full, every accept re-triggers a traceback.
  assign fill_inc = (fill_cnt == FULL) ? FULL : fill_cnt + FILL_W'(1);

  // Predecessor of the current state within the step addressed by rp.
  mux8to1_3bit u_pred_mux (
    .in0 (rd_tbl[0]),
    .in1 (rd_tbl[1]),
    .in2 (rd_tbl[2]),
    .in3 (rd_tbl[3]),
    .in4 (rd_tbl[4]),
    .in5 (rd_tbl[5]),
    .in6 (rd_tbl[6]),
    .in7 (rd_tbl[7]),
    .sel (cur),
    .out (pred_sel)
  );

  // Survivor memory; contents are meaningless until refilled after reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[wp] <= pred_in;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nxt = state;
    wp_nxt    = wp;
    rp_nxt    = rp;
    hop_nxt   = hop;
    fill_nxt  = fill_cnt;
    cur_nxt   = cur;
    bit_nxt   = bit_out;
    ov_nxt    = out_valid;
    mem_we    = 1'b0;
    unique case (state)
      ACCEPT: begin
        if (in_valid) begin
          mem_we   = 1'b1;
          wp_nxt   = wp + ADDR_W'(1);
          fill_nxt = fill_inc;
          if (fill_inc == FULL) begin
            cur_nxt   = best_in;
            rp_nxt    = wp;
            hop_nxt   = HOP_INIT;
            state_nxt = TRACE;
          end
        end
      end
      TRACE: begin
        // hop counts remaining hops; the cycle at zero registers the bit,
        // giving TB_DEPTH cycles from accept to out_valid.
        if (hop != '0) begin
          cur_nxt = pred_sel;
          rp_nxt  = rp - ADDR_W'(1);
          hop_nxt = hop - ADDR_W'(1);
        end else begin
          bit_nxt   = cur[STATE_W-1];
          ov_nxt    = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = ACCEPT;
        end
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCEPT;
      wp        <= '0;
      rp        <= '0;
      hop       <= '0;
      fill_cnt  <= '0;
      cur       <= '0;
      bit_out   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      wp        <= wp_nxt;
      rp        <= rp_nxt;
      hop       <= hop_nxt;
      fill_cnt  <= fill_nxt;
      cur       <= cur_nxt;
      bit_out   <= bit_nxt;
      out_valid <= ov_nxt;
    end
  end

`ifdef VITERBI_TB_DBG_EN
  assign dbg_fsm = state;

  // Count of transferred bits, wrapping at 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_bit_cnt <= '0;
    end else if (out_valid && out_ready) begin
      dbg_bit_cnt <= dbg_bit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_tb_ctrl.sv
// Directed self-checking bench for viterbi_tb_ctrl (TB_DEPTH=16 and TB_DEPTH=4 instances).
module tb_viterbi_tb_ctrl;
  import viterbi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, in_ready, bit_out, out_valid;
  logic [23:0] pred_in;
  logic [2:0]  best_in;

  logic        rst4, in_valid4, out_ready4, in_ready4, bit_out4, out_valid4;
  logic [23:0] pred_in4;
  logic [2:0]  best_in4;

`ifdef VITERBI_TB_DBG_EN
  logic [1:0]  dbg_fsm, dbg_fsm4;
  logic [15:0] dbg_cnt, dbg_cnt4;
`endif

  int tests = 0;
  int fails = 0;

  viterbi_tb_ctrl #(.TB_DEPTH(16), .ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst), .pred_in(pred_in), .best_in(best_in),
    .in_valid(in_valid), .in_ready(in_ready), .bit_out(bit_out),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef VITERBI_TB_DBG_EN
    , .dbg_fsm(dbg_fsm), .dbg_bit_cnt(dbg_cnt)
`endif
  );

  viterbi_tb_ctrl #(.TB_DEPTH(4), .ADDR_W(2)) u_dut4 (
    .clk(clk), .rst(rst4), .pred_in(pred_in4), .best_in(best_in4),
    .in_valid(in_valid4), .in_ready(in_ready4), .bit_out(bit_out4),
    .out_valid(out_valid4), .out_ready(out_ready4)
`ifdef VITERBI_TB_DBG_EN
    , .dbg_fsm(dbg_fsm4), .dbg_bit_cnt(dbg_cnt4)
`endif
  );

  // Input bit u_t of the encoded stream (u_t = 0 for t < 1).
  function automatic logic u_at(input int t);
    logic [0:7] pat;
    pat = 8'b10110010;
    if (t < 1) return 1'b0;
    return pat[(t - 1) % 8];
  endfunction

  // Ideal predecessor table for step t: pred(k) = {k[1:0], u_(t-3)}.
  function automatic logic [23:0] ideal_tbl(input int t);
    logic [23:0] r;
    logic [2:0]  kk;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      kk = 3'(k);
      r[3*k +: 3] = {kk[1:0], u_at(t - 3)};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_step(input logic [23:0] p, input logic [2:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_step_timeout: in_ready=%b required 1", in_ready);
    end
    pred_in  = p;
    best_in  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid, returns the bit (x on timeout) and transfers it.
  task automatic collect(output logic b);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      n++;
    end
    b = out_valid ? bit_out : 1'bx;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pred_in = '0; best_in = '0;
    tick();
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (bit_out !== 1'b0) begin fails++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
    rst = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
`ifdef VITERBI_TB_DBG_EN
    tests++; if (dbg_cnt !== 16'd0) begin fails++; $display("FAIL reset_dbg_cnt: got %0d want 0", dbg_cnt); end
    tests++; if (dbg_fsm !== 2'd0) begin fails++; $display("FAIL reset_dbg_fsm: got %0d want 0", dbg_fsm); end
`endif
  endtask

  // Fill with zero tables; checks silence for 15 steps and exact 16-cycle latency.
  task automatic check_zero_fill(input string tag);
    logic seen, busy_ok;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send_step(24'h000000, 3'b100);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL %s_early_output: out_valid seen during fill, want none", tag); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_fill_in_ready: got %b want 1", tag, in_ready); end
    send_step(24'h000000, 3'b100);
    seen = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
    end
    if (out_valid !== 1'b0) seen = 1'b1;
    tests++; if (seen) begin fails++; $display("FAIL %s_latency_early: out_valid before 16 cycles", tag); end
    tests++; if (!busy_ok) begin fails++; $display("FAIL %s_trace_in_ready: in_ready high during traceback, want 0", tag); end
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency_16: out_valid=%b want 1", tag, out_valid); end
    tests++; if (bit_out !== 1'b0) begin fails++; $display("FAIL %s_bit: got %b want 0", tag, bit_out); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_after_xfer_valid: got %b want 0", tag, out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_after_xfer_ready: got %b want 1", tag, in_ready); end
  endtask

  task automatic test_zero_table();
    check_zero_fill("zero");
`ifdef VITERBI_TB_DBG_EN
    tests++; if (dbg_cnt !== 16'd1) begin fails++; $display("FAIL zero_dbg_cnt: got %0d want 1", dbg_cnt); end
`endif
  endtask

  task automatic test_ones_table();
    logic b;
    do_reset();
    for (int i = 0; i < 16; i++) send_step(24'hFFFFFF, 3'b000);
    collect(b);
    tests++; if (b !== 1'b1) begin fails++; $display("FAIL ones_first_bit: got %b want 1", b); end
    for (int i = 0; i < 3; i++) begin
      send_step(24'hFFFFFF, 3'b000);
      collect(b);
      tests++; if (b !== 1'b1) begin fails++; $display("FAIL ones_bit_%0d: got %b want 1", i, b); end
    end
  endtask

  task automatic test_backpressure();
    logic stable;
    int n;
    send_step(24'hFFFFFF, 3'b000);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || bit_out !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      pred_in  = 24'h000000;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tests++; if (!stable) begin fails++; $display("FAIL bp_hold: out_valid=%b bit_out=%b in_ready=%b want 1,1,0", out_valid, bit_out, in_ready); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_still_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_xfer_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_xfer_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    logic b, early;
    int nout;
    do_reset();
    early = 1'b0;
    nout = 0;
    for (int t = 1; t <= 40; t++) begin
      send_step(ideal_tbl(t), {u_at(t), u_at(t - 1), u_at(t - 2)});
      if (t < 16) begin
        if (out_valid !== 1'b0) early = 1'b1;
      end else begin
        collect(b);
        nout++;
        tests++;
        if (b !== u_at(t - 15)) begin
          fails++;
          $display("FAIL wrap_bit_%0d: got %b want %b", t - 15, b, u_at(t - 15));
        end
      end
    end
    tests++; if (early) begin fails++; $display("FAIL wrap_early: out_valid during fill"); end
    tests++; if (nout != 25) begin fails++; $display("FAIL wrap_count: got %0d want 25", nout); end
  endtask

  task automatic test_reset_mid_trace();
    logic seen;
    send_step(24'h000000, 3'b100);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready_during: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready_after: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    tests++; if (seen) begin fails++; $display("FAIL midrst_discard: out_valid rose after abort, want 0"); end
    check_zero_fill("midrst");
  endtask

  task automatic test_param_variant();
    logic seen;
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    seen = 1'b0;
    pred_in4 = 24'h000000;
    best_in4 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      if (out_valid4 !== 1'b0) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL d4_early_output: out_valid during fill"); end
    tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL d4_in_ready: got %b want 1", in_ready4); end
    for (int s = 0; s < 2; s++) begin
      in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (out_valid4 !== 1'b0) seen = 1'b1;
        tick();
      end
      if (out_valid4 !== 1'b0) seen = 1'b1;
      tests++; if (seen) begin fails++; $display("FAIL d4_latency_early_%0d: out_valid before 4 cycles", s); end
      tick();
      tests++; if (out_valid4 !== 1'b1) begin fails++; $display("FAIL d4_latency_4_%0d: out_valid=%b want 1", s, out_valid4); end
      tests++; if (bit_out4 !== 1'b0) begin fails++; $display("FAIL d4_bit_%0d: got %b want 0", s, bit_out4); end
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
`ifdef VITERBI_TB_DBG_EN
      tests++; if (dbg_cnt4 !== 16'(s + 1)) begin fails++; $display("FAIL d4_dbg_cnt_%0d: got %0d want %0d", s, dbg_cnt4, s + 1); end
      tests++; if (dbg_fsm4 !== 2'd0) begin fails++; $display("FAIL d4_dbg_fsm_%0d: got %0d want 0", s, dbg_fsm4); end
`endif
    end
  endtask

  initial begin
    rst4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b0; pred_in4 = '0; best_in4 = '0;
    test_reset();
    test_zero_table();
    test_ones_table();
    test_backpressure();
    test_wrap();
    test_reset_mid_trace();
    test_param_variant();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
